gauss_window_gen: RTL and testbench

//  Producer side of the 3x3 Gaussian kernel interface. Takes a raster pixel stream with a valid/ready handshake.

---
 rtl/gauss_pkg.sv | 21 ++
 rtl/line_buffer.sv | 25 ++
 rtl/gauss_window_gen.sv | 138 +++++++++++++
 tb/tb_gauss_window_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// gauss_pkg: corner codes, FSM state encoding and corner decode helper for gauss_window_gen
package gauss_pkg;
   localparam logic [3:0] CT_NONE     = 4'd0;
   localparam logic [3:0] CT_TL       = 4'd1;
   localparam logic [3:0] CT_TR       = 4'd2;
   localparam logic [3:0] CT_LEFT     = 4'd3;
   localparam logic [3:0] CT_RIGHT    = 4'd4;
   localparam logic [3:0] CT_BL       = 4'd5;
   localparam logic [3:0] CT_BR       = 4'd6;
   localparam logic [3:0] CT_EDGE_TB  = 4'd7;
   localparam logic [3:0] CT_INTERIOR = 4'd8;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

   // Left/right and top/bottom are mutually exclusive because the image is at least 4x3.
   function automatic logic [3:0] corner_code(input logic l, input logic r, input logic t, input logic b);
      if (t) return l ? CT_TL : r ? CT_TR : CT_EDGE_TB;
      if (b) return l ? CT_BL : r ? CT_BR : CT_EDGE_TB;
      return l ? CT_LEFT : r ? CT_RIGHT : CT_INTERIOR;
   endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: DEPTH-entry delay line; delayed is the value written DEPTH enabled beats ago
//  clk, rst : clock, async active-high reset (pointer only, storage is not cleared)
//  en       : advance one beat
//  data     : value written on this beat
//  delayed  : value written DEPTH beats earlier
module line_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 640
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] delayed
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] P_LAST = AW'(DEPTH - 1);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         ptr;
   assign delayed = mem[ptr];
   always_ff @(posedge clk) if (en) mem[ptr] <= data;
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr <= '0;
      else if (en) ptr <= ptr == P_LAST ? '0 : ptr + 1'b1;
endmodule

// File: rtl/gauss_window_gen.sv
// gauss_window_gen: raster stream to registered, edge-masked 3x3 windows with corner codes
//  clk, rst           : clock, async active-high reset
//  sof, in_valid      : start of frame / pixel valid; in_ready accepts when high
//  in_data            : raster pixel
//  lineK_dataJ        : pixel (y+1-K, x+1-J) of the window centred (x,y), 0 outside the image
//  corner_type        : window position code, 0 when out_valid=0
//  out_valid          : one window this cycle
//  frame_done         : pulses with the last window of a frame
module gauss_window_gen
   import gauss_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sof,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] line0_data0,
   output logic [DATA_WIDTH-1:0] line0_data1,
   output logic [DATA_WIDTH-1:0] line0_data2,
   output logic [DATA_WIDTH-1:0] line1_data0,
   output logic [DATA_WIDTH-1:0] line1_data1,
   output logic [DATA_WIDTH-1:0] line1_data2,
   output logic [DATA_WIDTH-1:0] line2_data0,
   output logic [DATA_WIDTH-1:0] line2_data1,
   output logic [DATA_WIDTH-1:0] line2_data2,
   output logic [3:0]            corner_type,
   output logic                  out_valid,
   output logic                  frame_done
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int FW = $clog2(IMG_W + 1);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [XW-1:0] X_PEN  = XW'(IMG_W - 2);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic [YW-1:0] Y_PEN  = YW'(IMG_H - 2);
   localparam logic [FW-1:0] F_LAST = FW'(IMG_W);

   state_t                state;
   logic [XW-1:0]         cx;
   logic [YW-1:0]         cy;
   logic [FW-1:0]         fc;
   logic [DATA_WIDTH-1:0] raw [3][2];
   logic [DATA_WIDTH-1:0] win [3][3];
   logic [DATA_WIDTH-1:0] nw  [3][3];
   logic [DATA_WIDTH-1:0] pix, l1, l2;
   logic [2:0]            row_ok, col_ok;
   logic                  start, take, shift, emit, last;

   // (cx,cy) is the centre of the window produced on the current beat.
   assign start  = in_valid & in_ready & sof;
   assign take   = in_valid & in_ready & (sof | state != S_IDLE);
   assign shift  = take | state == S_FLUSH;
   assign emit   = (state == S_RUN & take & ~sof) | state == S_FLUSH;
   assign last   = cx == X_LAST & cy == Y_LAST;
   assign pix    = state == S_FLUSH ? '0 : in_data;
   assign row_ok = {cy != '0, 1'b1, cy != Y_LAST};
   // Column masks also drop pixels that wrapped in from the neighbouring line.
   assign col_ok = {cx != '0, 1'b1, cx != X_LAST};

   line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb1 (
      .clk(clk), .rst(rst), .en(shift), .data(pix), .delayed(l1));
   line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb2 (
      .clk(clk), .rst(rst), .en(shift), .data(l1), .delayed(l2));

   // Column 0 is the incoming column; older columns come from the raw shift registers.
   always_comb begin
      nw[0][0] = pix;
      nw[1][0] = l1;
      nw[2][0] = l2;
      for (int k = 0; k < 3; k++) begin
         nw[k][1] = raw[k][0];
         nw[k][2] = raw[k][1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         frame_done  <= 1'b0;
         corner_type <= CT_NONE;
         cx          <= '0;
         cy          <= '0;
         fc          <= '0;
         raw         <= '{default: '0};
         win         <= '{default: '0};
      end else begin
         out_valid   <= emit;
         frame_done  <= emit & last;
         corner_type <= emit ? corner_code(cx == '0, cx == X_LAST, cy == '0, cy == Y_LAST) : CT_NONE;
         if (shift)
            for (int k = 0; k < 3; k++) begin
               raw[k][0] <= nw[k][0];
               raw[k][1] <= nw[k][1];
            end
         if (emit) begin
            for (int k = 0; k < 3; k++)
               for (int j = 0; j < 3; j++)
                  win[k][j] <= row_ok[k] & col_ok[j] ? nw[k][j] : '0;
            cx <= cx == X_LAST ? '0 : cx + 1'b1;
            if (cx == X_LAST) cy <= cy == Y_LAST ? '0 : cy + 1'b1;
         end
         // sof restarts the frame from any accepting state, discarding the old one.
         if (start) begin
            state <= S_FILL;
            fc    <= FW'(1);
            cx    <= '0;
            cy    <= '0;
         end else if (state == S_FILL && take) begin
            fc <= fc + 1'b1;
            if (fc == F_LAST) state <= S_RUN;
         end else if (state == S_RUN && emit && cx == X_PEN && cy == Y_PEN) begin
            state    <= S_FLUSH;
            in_ready <= 1'b0;
         end else if (state == S_FLUSH && last) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
         end
      end
   end

   assign line0_data0 = win[0][0];
   assign line0_data1 = win[0][1];
   assign line0_data2 = win[0][2];
   assign line1_data0 = win[1][0];
   assign line1_data1 = win[1][1];
   assign line1_data2 = win[1][2];
   assign line2_data0 = win[2][0];
   assign line2_data1 = win[2][1];
   assign line2_data2 = win[2][2];
endmodule

// File: tb/tb_gauss_window_gen.sv
// tb_gauss_window_gen: directed frames against a coordinate-level window model plus literal pins
module tb_gauss_window_gen;
   localparam int W = 4;
   localparam int H = 3;

   typedef struct packed {
      logic [8:0][7:0] d;
      logic [3:0]      ct;
      logic            done;
   } win_t;

   logic       clk = 0, rst = 1, sof = 0, in_valid = 0;
   logic [7:0] in_data = 0;
   logic       in_ready, out_valid, frame_done;
   logic [3:0] corner_type;
   logic [7:0] l00, l01, l02, l10, l11, l12, l20, l21, l22;
   logic [8:0][7:0] dut_d;

   int   tests = 0, fails = 0, flush_cycles = 0, done_count = 0;
   int   img [W*H];
   win_t exp_q [$];
   win_t obs [$];

   gauss_window_gen #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .line0_data0(l00), .line0_data1(l01), .line0_data2(l02),
      .line1_data0(l10), .line1_data1(l11), .line1_data2(l12),
      .line2_data0(l20), .line2_data1(l21), .line2_data2(l22),
      .corner_type(corner_type), .out_valid(out_valid), .frame_done(frame_done));

   always #5 clk = ~clk;
   assign dut_d = {l22, l21, l20, l12, l11, l10, l02, l01, l00};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   // Expected window for centre index c, straight from image coordinates.
   task automatic push_exp(input int c, input bit done);
      int x, y, r, q, rc, cc;
      int ct_tab [3][3];
      win_t e;
      ct_tab = '{'{1, 7, 2}, '{3, 8, 4}, '{5, 7, 6}};
      x = c % W;
      y = c / W;
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < 3; j++) begin
            r = y + 1 - k;
            q = x + 1 - j;
            e.d[k*3+j] = (r >= 0 && r < H && q >= 0 && q < W) ? 8'(img[r*W+q]) : 8'd0;
         end
      rc = y == 0 ? 0 : y == H - 1 ? 2 : 1;
      cc = x == 0 ? 0 : x == W - 1 ? 2 : 1;
      e.ct = 4'(ct_tab[rc][cc]);
      e.done = done;
      exp_q.push_back(e);
   endtask

   task automatic model_accept(input int n);
      if (n >= W + 1) push_exp(n - W - 1, 0);
      if (n == W*H - 1)
         for (int c = W*H - W - 1; c < W*H; c++) push_exp(c, c == W*H - 1);
   endtask

   always @(negedge clk) if (!rst) begin
      if (!in_ready) flush_cycles++;
      if (frame_done) done_count++;
      if (out_valid) begin
         obs.push_back('{d: dut_d, ct: corner_type, done: frame_done});
         if (exp_q.size() == 0) chk("unexpected window", 1, 0);
         else begin
            win_t e;
            e = exp_q.pop_front();
            chk("window data", dut_d, e.d);
            chk("corner_type", corner_type, e.ct);
            chk("frame_done", frame_done, e.done);
         end
      end else if (corner_type != 0 || frame_done) begin
         chk("idle corner_type", corner_type, 0);
         chk("idle frame_done", frame_done, 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int t = 0; t < 100 && !in_ready; t++) step();
      if (!in_ready) chk("in_ready timeout", in_ready, 1);
   endtask

   task automatic drain();
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) step();
      chk("drain expected windows", exp_q.size(), 0);
      step();
   endtask

   task automatic run_frame(input int base, input int npix, input bit gaps);
      for (int i = 0; i < W*H; i++) img[i] = base + i;
      for (int n = 0; n < npix; n++) begin
         wait_ready();
         if (gaps && n > 0) repeat ($urandom_range(1, 3)) step();
         sof = n == 0;
         in_valid = 1;
         in_data = 8'(base + n);
         step();
         sof = 0;
         in_valid = 0;
         model_accept(n);
         if (n == W + 1 && !gaps) begin
            @(negedge clk);
            chk("first window latency", out_valid, 1);
         end
      end
   endtask

   task automatic check_reset_values();
      @(negedge clk);
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset frame_done", frame_done, 0);
      chk("reset corner_type", corner_type, 0);
      chk("reset window", dut_d, 0);
   endtask

   task automatic check_frame_literals(input int base);
      int seq [12];
      logic [8:0][7:0] first_w, int_w;
      seq = '{1, 7, 7, 2, 3, 8, 8, 4, 5, 7, 7, 6};
      first_w = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6};
      int_w = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
      chk("window count", obs.size() - base, 12);
      if (obs.size() - base == 12) begin
         for (int i = 0; i < 12; i++) chk("corner sequence", obs[base+i].ct, seq[i]);
         chk("first window literal", obs[base].d, first_w);
         chk("interior (1,1) literal", obs[base+5].d, int_w);
         chk("interior corner literal", obs[base+5].ct, 8);
         chk("frame_done on 12th", obs[base+11].done, 1);
         chk("no frame_done on 11th", obs[base+10].done, 0);
      end
   endtask

   initial begin
      int b, d;
      // 1: reset state, pixels without sof are ignored
      repeat (2) step();
      check_reset_values();
      #1 rst = 0;
      step();
      in_valid = 1;
      repeat (3) step();
      in_valid = 0;
      repeat (3) step();
      chk("no window without sof", obs.size(), 0);
      // 2: back-to-back frame
      b = obs.size();
      flush_cycles = 0;
      d = done_count;
      run_frame(1, 12, 0);
      drain();
      check_frame_literals(b);
      chk("flush in_ready low cycles", flush_cycles, 5);
      chk("frame_done pulses", done_count - d, 1);
      // 3: same frame with idle gaps
      b = obs.size();
      run_frame(1, 12, 1);
      drain();
      check_frame_literals(b);
      // 5: abort at pixel 8, new frame with different data
      b = obs.size();
      d = done_count;
      run_frame(101, 7, 0);
      run_frame(21, 12, 0);
      drain();
      chk("windows across abort", obs.size() - b, 14);
      chk("frame_done across abort", done_count - d, 1);
      // 6: async reset during flush
      d = done_count;
      run_frame(61, 12, 0);
      step();
      step();
      rst = 1;
      exp_q.delete();
      check_reset_values();
      step();
      rst = 0;
      step();
      chk("no frame_done after reset", done_count - d, 0);
      b = obs.size();
      d = done_count;
      run_frame(1, 12, 0);
      drain();
      check_frame_literals(b);
      chk("frame_done after reset frame", done_count - d, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
